// File: rtl/clk_activity_monitor_pkg.sv
// Shared types and defaults for the clock activity monitor.
// State encoding plus default counter width and stuck timeout.
package clk_activity_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int DEF_CNT_W   = 12;
    localparam int DEF_TIMEOUT = 4000;

endpackage

// File: rtl/clk_activity_monitor_sync.sv
// Brings the monitored clock into the CLK domain.
// Two synchronizer flops plus a history flop for rising-edge detect.
module clk_activity_monitor_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic s2,
    output logic rise
);

    logic s1;
    logic s3;

    // Synchronizer chain and edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/clk_activity_monitor.sv
// Measures the period of I_MON in CLK cycles, flags out-of-window and stuck clocks.
// Define CLK_ACTIVITY_MONITOR_DUTY_EN to also measure the high time on HIGH_T.
module clk_activity_monitor
    import clk_activity_monitor_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic             I_MON,
    input  logic [CNT_W-1:0] PER_MIN,
    input  logic [CNT_W-1:0] PER_MAX,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_T,
    output logic             VALID,
    output logic             ERR_FAST,
    output logic             ERR_SLOW,
    output logic             STUCK
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO      = CNT_W'(TIMEOUT);

    logic             s2;
    logic             rise;
    state_t           state,    state_n;
    logic [CNT_W-1:0] cnt,      cnt_n;
    logic [CNT_W-1:0] tcnt,     tcnt_n;
    logic [CNT_W-1:0] period_q, period_n;
    logic             valid_q,  valid_n;
    logic             fast_q,   fast_n;
    logic             slow_q,   slow_n;
    logic             stuck_q,  stuck_n;
    logic [CNT_W-1:0] tcnt_inc;

`ifdef CLK_ACTIVITY_MONITOR_DUTY_EN
    logic [CNT_W-1:0] hcnt,   hcnt_n;
    logic [CNT_W-1:0] high_q, high_n;
`else
    logic unused_s2;
    assign unused_s2 = s2;
`endif

    clk_activity_monitor_sync u_sync (
        .clk   (CLK),
        .rst_n (RN),
        .d     (I_MON),
        .s2    (s2),
        .rise  (rise)
    );

    assign tcnt_inc = tcnt + 1'b1;

    // Next state, counters and output values
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        tcnt_n   = tcnt;
        period_n = period_q;
        valid_n  = 1'b0;
        fast_n   = fast_q;
        slow_n   = slow_q;
        stuck_n  = stuck_q;
`ifdef CLK_ACTIVITY_MONITOR_DUTY_EN
        hcnt_n   = hcnt;
        high_n   = high_q;
`endif
        if (!EN) begin
            state_n  = IDLE;
            cnt_n    = '0;
            tcnt_n   = '0;
            period_n = '0;
            fast_n   = 1'b0;
            slow_n   = 1'b0;
            stuck_n  = 1'b0;
`ifdef CLK_ACTIVITY_MONITOR_DUTY_EN
            hcnt_n   = '0;
            high_n   = '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = ACQUIRE;
                    cnt_n   = '0;
                    tcnt_n  = '0;
                end
                ACQUIRE: begin
                    if (rise) begin
                        state_n = MEASURE;
                        cnt_n   = CNT_ONE;
                        tcnt_n  = '0;
                        stuck_n = 1'b0;
`ifdef CLK_ACTIVITY_MONITOR_DUTY_EN
                        hcnt_n  = '0;
`endif
                    end else if (tcnt_inc == TO) begin
                        stuck_n = 1'b1;
                        tcnt_n  = '0;
                    end else begin
                        tcnt_n  = tcnt_inc;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_n = cnt;
                        fast_n   = (cnt < PER_MIN);
                        slow_n   = (cnt > PER_MAX);
                        valid_n  = 1'b1;
                        cnt_n    = CNT_ONE;
`ifdef CLK_ACTIVITY_MONITOR_DUTY_EN
                        high_n   = hcnt;
                        hcnt_n   = '0;
`endif
                    end else if (cnt == TO) begin
                        stuck_n = 1'b1;
                        state_n = ACQUIRE;
                        cnt_n   = '0;
                        tcnt_n  = '0;
`ifdef CLK_ACTIVITY_MONITOR_DUTY_EN
                        hcnt_n  = '0;
`endif
                    end else begin
                        if (cnt != CNT_MAX) cnt_n = cnt + 1'b1;
`ifdef CLK_ACTIVITY_MONITOR_DUTY_EN
                        if (s2 && hcnt != CNT_MAX) hcnt_n = hcnt + 1'b1;
`endif
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state    <= IDLE;
            cnt      <= '0;
            tcnt     <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            fast_q   <= 1'b0;
            slow_q   <= 1'b0;
            stuck_q  <= 1'b0;
`ifdef CLK_ACTIVITY_MONITOR_DUTY_EN
            hcnt     <= '0;
            high_q   <= '0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            tcnt     <= tcnt_n;
            period_q <= period_n;
            valid_q  <= valid_n;
            fast_q   <= fast_n;
            slow_q   <= slow_n;
            stuck_q  <= stuck_n;
`ifdef CLK_ACTIVITY_MONITOR_DUTY_EN
            hcnt     <= hcnt_n;
            high_q   <= high_n;
`endif
        end
    end

    assign PERIOD   = period_q;
    assign VALID    = valid_q;
    assign ERR_FAST = fast_q;
    assign ERR_SLOW = slow_q;
    assign STUCK    = stuck_q;
`ifdef CLK_ACTIVITY_MONITOR_DUTY_EN
    assign HIGH_T   = high_q;
`else
    assign HIGH_T   = '0;
`endif

endmodule

// File: doc/clk_activity_monitor.md
# clk_activity_monitor

Synchronous monitor sitting at the receiving end of a clock-tree branch built from the library's clock inverters/buffers. It samples a monitored clock (I_MON) in the CLK domain and measures its period (and optionally its high time) in CLK cycles. It flags periods outside a programmable window and flags a stuck or stopped clock. Used for clock-tree bring-up and as a safety monitor on gated or derived clocks.

## Interface
Parameters:
- CNT_W, 12, width of period/high-time counters and threshold ports.
- TIMEOUT, 4000, CLK cycles without a monitored rising edge before STUCK is flagged; must be > 0 and < 2^CNT_W - 1.

Ports (clock and reset first):
- CLK  input  1  monitor clock; all state updates on its rising edge.
- RN  input  1  asynchronous, active-low reset; one clock domain only.
- EN  input  1  monitor enable; low forces IDLE.
- I_MON  input  1  monitored clock, asynchronous to CLK; frequency ≤ CLK/4.
- PER_MIN  input  CNT_W  minimum legal period (CLK cycles), quasi-static.
- PER_MAX  input  CNT_W  maximum legal period (CLK cycles), quasi-static.
- PERIOD  output  CNT_W  last measured period.
- HIGH_T  output  CNT_W  last measured high time (duty build only; else tied 0).
- VALID  output  1  one-cycle pulse when PERIOD/HIGH_T/ERR_* update.
- ERR_FAST  output  1  last period < PER_MIN.
- ERR_SLOW  output  1  last period > PER_MAX.
- STUCK  output  1  no rising edge of I_MON for TIMEOUT cycles.

## Operation
- Input path: 2-flop synchronizer (s1, s2) plus history flop s3, all reset 0; rise = s2 & ~s3.
- States: IDLE, ACQUIRE, MEASURE.
- IDLE: counters 0; outputs held at reset values. EN=1 -> ACQUIRE.
- ACQUIRE: timeout counter tcnt increments each cycle. rise -> MEASURE, cnt=1, STUCK cleared; no VALID (first edge only starts timing). tcnt reaches TIMEOUT -> STUCK=1, tcnt restarts at 0, stay ACQUIRE.
- MEASURE: cnt increments each cycle, saturating at 2^CNT_W-1. On rise: PERIOD=cnt, ERR_FAST=(cnt<PER_MIN), ERR_SLOW=(cnt>PER_MAX), VALID=1 for one cycle, cnt=1. If cnt reaches TIMEOUT with no rise -> STUCK=1, -> ACQUIRE; PERIOD and ERR_* keep their last values.
- Rise and timeout in the same cycle: rise wins, no STUCK.
- ERR_* are not sticky; each VALID overwrites them. STUCK persists until the next rise in ACQUIRE.
- EN low in any state: -> IDLE next cycle, all outputs return to reset values, in-flight measurement discarded.
- PER_MIN > PER_MAX: both compares apply independently. Every measurement then sets at least one ERR flag.

## Timing
- Reset values: PERIOD=0, HIGH_T=0, VALID=0, ERR_FAST=0, ERR_SLOW=0, STUCK=0, state IDLE.
- Latency: I_MON rising edge -> VALID is 3-4 CLK cycles (synchronizer + edge detect + output register). Outputs are registered.
- Measured period has ±1 CLK quantization due to asynchronous sampling.
- Asserting RN mid-measurement clears everything asynchronously. After RN deassertion, the first rise in ACQUIRE never produces VALID.

## Configuration
- CLK_ACTIVITY_MONITOR_DUTY_EN defined: adds high-time counter hcnt. hcnt increments on cycles with s2=1 during MEASURE, saturates, and is reset to 0 on rise. HIGH_T is loaded with hcnt on the same cycle as PERIOD.
- Not defined: no hcnt logic; HIGH_T is constant 0. All other behaviour is identical.

## Structure
- Package clk_activity_monitor_pkg: state enum (IDLE, ACQUIRE, MEASURE) and default CNT_W/TIMEOUT constants.
- One sub-module, clk_activity_monitor_sync: 2-flop synchronizer plus history flop, async active-low reset; outputs s2 and rise.

## Test plan
- I_MON period 10 CLK, PER_MIN=8, PER_MAX=12 -> VALID every 10 cycles after the first edge, PERIOD=10 (±1), no ERR flags.
- I_MON period 20, PER_MAX=12 -> ERR_SLOW=1 on each VALID. Switch to period 6 with PER_MIN=8 -> ERR_FAST=1, ERR_SLOW=0.
- I_MON held 0 after running, TIMEOUT=100 -> STUCK=1 100 cycles after the last counted edge, PERIOD unchanged. Restart I_MON -> STUCK clears on the first rise, next VALID after one full period.
- Duty build, I_MON 12 cycles period with 3 high -> HIGH_T=3 (±1), PERIOD=12. Non-duty build -> HIGH_T=0.
- EN deasserted mid-period -> next cycle all outputs 0, IDLE. Re-enable -> the first rise gives no VALID.
- RN pulsed low mid-measurement -> outputs 0 immediately. Rise and timeout forced in the same cycle -> VALID=1, STUCK=0.
